// File: rtl/pipeline_mem_arbiter_if.sv
// pipeline_mem_arbiter_if
//   Shared memory bus between the arbiter and the cache/physical memory.
//   master : arbiter side (drives strobes, address, write data, byte enables)
//   slave  : memory side  (drives read data and the completion pulse)
//   mem_read/mem_write  strobes, at most one high
//   mem_mbe             byte enables
//   mem_addr/mem_wdata  address and write data
//   mem_rdata           read word
//   mem_resp            one-cycle completion pulse
interface pipeline_mem_arbiter_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_mbe, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_mbe, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter
//   Arbitrates the fetch (inst_*) and load/store (data_*) ports onto one
//   shared memory bus. All outputs are registered. Simultaneous requests
//   alternate between the ports; a sticky watchdog flags a memory that
//   takes TIMEOUT or more cycles to answer.
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   inst_read/addr    fetch request, held until inst_resp
//   inst_resp/rdata   one-cycle completion pulse and fetched word
//   data_read/write   load/store request, held until data_resp
//   data_mbe/addr/wdata  store byte enables, address, store data
//   data_resp/rdata   one-cycle completion pulse and load word
//   mem               shared memory bus (master side)
//   mem_timeout       sticky watchdog flag
module pipeline_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inst_read,
  input  logic [31:0]                   inst_addr,
  output logic                          inst_resp,
  output logic [31:0]                   inst_rdata,
  input  logic                          data_read,
  input  logic                          data_write,
  input  logic [3:0]                    data_mbe,
  input  logic [31:0]                   data_addr,
  input  logic [31:0]                   data_wdata,
  output logic                          data_resp,
  output logic [31:0]                   data_rdata,
  pipeline_mem_arbiter_if.master        mem,
  output logic                          mem_timeout
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
  typedef enum logic       {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

  state_e      state_q, state_d;
  owner_e      grant_q, last_q;
  logic [15:0] cnt_q;

  logic        inst_pend, data_pend;
  logic        pick_data, grant_wr;
  logic        do_grant, do_done, do_wait;
  logic [15:0] cnt_nxt;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inst_pend || data_pend) state_d = BUSY;
      BUSY:    if (mem.mem_resp)           state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output/decode logic feeding the registered datapath
  always_comb begin
    inst_pend = inst_read;
    data_pend = data_read || data_write;
    // DATA wins a tie unless it was served last, so ties alternate
    pick_data = data_pend && (!inst_pend || last_q != OWN_DATA);
    grant_wr  = pick_data && data_write;
    do_grant  = (state_q == IDLE) && (inst_pend || data_pend);
    do_done   = (state_q == BUSY) && mem.mem_resp;
    do_wait   = (state_q == BUSY) && !mem.mem_resp;
    cnt_nxt   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q       <= OWN_INST;
      last_q        <= OWN_INST;
      cnt_q         <= '0;
      mem_timeout   <= 1'b0;
      mem.mem_read  <= 1'b0;
      mem.mem_write <= 1'b0;
      mem.mem_mbe   <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      inst_resp     <= 1'b0;
      inst_rdata    <= '0;
      data_resp     <= 1'b0;
      data_rdata    <= '0;
    end else begin
      if (do_grant) begin
        grant_q       <= pick_data ? OWN_DATA : OWN_INST;
        mem.mem_read  <= !grant_wr;
        mem.mem_write <= grant_wr;
        mem.mem_mbe   <= grant_wr ? data_mbe : 4'hF;
        mem.mem_addr  <= pick_data ? data_addr : inst_addr;
        mem.mem_wdata <= data_wdata;
        cnt_q         <= '0;
      end
      if (do_wait) begin
        cnt_q <= cnt_nxt;
        // set on the edge the count reaches the limit, not one later
        if (cnt_nxt >= TO_LIMIT) mem_timeout <= 1'b1;
      end
      if (do_done) begin
        mem.mem_read  <= 1'b0;
        mem.mem_write <= 1'b0;
        last_q        <= grant_q;
        if (grant_q == OWN_DATA) begin
          data_resp  <= 1'b1;
          data_rdata <= mem.mem_rdata;
        end else begin
          inst_resp  <= 1'b1;
          inst_rdata <= mem.mem_rdata;
        end
      end
      if (state_q == RESP) begin
        inst_resp <= 1'b0;
        data_resp <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
module tb_pipeline_mem_arbiter;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_exp_t;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } resp_exp_t;

  logic        clk, rst_n;
  logic        inst_read, inst_resp;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_read, data_write, data_resp;
  logic [3:0]  data_mbe;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_timeout;
  logic        mresp, stray;
  logic [31:0] mrdata;
  int          mem_lat;
  int          checks, failures, resp_cnt;

  mem_exp_t  mq[$];
  resp_exp_t rq[$];

  pipeline_mem_arbiter_if mem_if ();

  assign mem_if.mem_resp  = mresp | stray;
  assign mem_if.mem_rdata = mrdata;

  pipeline_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .inst_read  (inst_read),
    .inst_addr  (inst_addr),
    .inst_resp  (inst_resp),
    .inst_rdata (inst_rdata),
    .data_read  (data_read),
    .data_write (data_write),
    .data_mbe   (data_mbe),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_resp  (data_resp),
    .data_rdata (data_rdata),
    .mem        (mem_if),
    .mem_timeout(mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // mode 0: inst, 1: data, 2: either
  task automatic wait_resp(input int mode);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk); #1;
      hit = (mode == 0) ? inst_resp : (mode == 1) ? data_resp : (inst_resp || data_resp);
    end
    if (!hit) chk("resp_wait_expired", 0, 1);
  endtask

  task automatic wait_strobe();
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk); #1;
      hit = mem_if.mem_read || mem_if.mem_write;
    end
    if (!hit) chk("strobe_wait_expired", 0, 1);
  endtask

  task automatic push(input bit is_data, input logic wr, input logic [31:0] addr,
                      input logic [3:0] mbe, input logic [31:0] wdata, input logic [31:0] rdata);
    mem_exp_t  m;
    resp_exp_t r;
    m.wr = wr; m.addr = addr; m.mbe = mbe; m.wdata = wdata; m.rdata = rdata;
    r.is_data = is_data; r.rdata = rdata;
    mq.push_back(m);
    rq.push_back(r);
  endtask

  // memory model: checks each new transaction, answers after mem_lat cycles
  initial begin : mem_model
    bit       in_flight;
    int       mcnt;
    mem_exp_t e;
    mresp = 0; mrdata = 0; in_flight = 0; mcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mresp = 0; in_flight = 0;
      end else if (mresp) begin
        mresp = 0; in_flight = 0;
      end else if (in_flight) begin
        mcnt--;
        if (mcnt <= 0) mresp = 1;
      end else if (mem_if.mem_read || mem_if.mem_write) begin
        chk("mem_one_strobe", 32'(mem_if.mem_read & mem_if.mem_write), 0);
        if (mq.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          e = mq.pop_front();
          chk("mem_dir_write", 32'(mem_if.mem_write), 32'(e.wr));
          chk("mem_addr", mem_if.mem_addr, e.addr);
          chk("mem_mbe", 32'(mem_if.mem_mbe), 32'(e.mbe));
          if (e.wr) chk("mem_wdata", mem_if.mem_wdata, e.wdata);
          mrdata = e.rdata;
        end
        in_flight = 1;
        if (mem_lat == 0) mresp = 1;
        else mcnt = mem_lat;
      end
    end
  end

  // response monitor: pops the scoreboard, flags stretched pulses
  initial begin : resp_mon
    logic pi, pd;
    resp_exp_t e;
    pi = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (inst_resp || data_resp) begin
        resp_cnt++;
        if (rq.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("resp_port", 32'(data_resp), 32'(e.is_data));
          chk("resp_rdata", data_resp ? data_rdata : inst_rdata, e.rdata);
        end
      end
      if ((inst_resp && pi) || (data_resp && pd)) chk("resp_pulse_len", 1, 0);
      pi = inst_resp; pd = data_resp;
    end
  end

  initial begin
    int base;
    checks = 0; failures = 0; resp_cnt = 0;
    inst_read = 0; inst_addr = 0; data_read = 0; data_write = 0;
    data_mbe = 0; data_addr = 0; data_wdata = 0; stray = 0; mem_lat = 1;
    rst_n = 1;
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_strobes", 32'({mem_if.mem_read, mem_if.mem_write}), 0);
    chk("rst_mbe", 32'(mem_if.mem_mbe), 0);
    chk("rst_addr", mem_if.mem_addr, 0);
    chk("rst_wdata", mem_if.mem_wdata, 0);
    chk("rst_resps", 32'({inst_resp, data_resp}), 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_timeout", 32'(mem_timeout), 0);
    #1 rst_n = 1;

    // single fetch, memory answers 2 cycles after the strobe
    mem_lat = 2;
    push(0, 0, 32'h60, 4'hF, 0, 32'h13);
    inst_addr = 32'h60; inst_read = 1;
    wait_resp(0);
    inst_read = 0;
    chk("fetch_inst_rdata", inst_rdata, 32'h13);

    // store, then store with read also high (write wins)
    mem_lat = 1;
    push(1, 1, 32'h104, 4'b0011, 32'hDEADBEEF, 32'h5A5A0000);
    data_addr = 32'h104; data_wdata = 32'hDEADBEEF; data_mbe = 4'b0011; data_write = 1;
    wait_resp(1);
    data_write = 0;
    push(1, 1, 32'h108, 4'b1100, 32'h12345678, 32'h0BADF00D);
    data_addr = 32'h108; data_wdata = 32'h12345678; data_mbe = 4'b1100;
    data_write = 1; data_read = 1;
    wait_resp(1);
    data_write = 0; data_read = 0;
    repeat (2) @(negedge clk);
    chk("store_rdata_hold", data_rdata, 32'h0BADF00D);

    // fairness after reset: DATA, INST, DATA, INST
    #1 rst_n = 0;
    @(negedge clk); #1 rst_n = 1;
    push(1, 0, 32'h1000, 4'hF, 0, 32'h11);
    push(0, 0, 32'h2000, 4'hF, 0, 32'h22);
    push(1, 0, 32'h1004, 4'hF, 0, 32'h33);
    push(0, 0, 32'h2004, 4'hF, 0, 32'h44);
    data_addr = 32'h1000; inst_addr = 32'h2000; data_read = 1; inst_read = 1;
    for (int n = 0; n < 4; n++) begin
      wait_resp(2);
      if (data_resp) data_addr = data_addr + 4;
      else           inst_addr = inst_addr + 4;
    end
    data_read = 0; inst_read = 0;
    repeat (2) @(negedge clk);

    // held request at minimum latency: regrant 3 cycles after mem_resp
    mem_lat = 0;
    push(0, 0, 32'h200, 4'hF, 0, 32'hA1);
    push(0, 0, 32'h200, 4'hF, 0, 32'hA2);
    inst_addr = 32'h200; inst_read = 1;
    wait_resp(0);
    @(negedge clk); #1 chk("held_gap_idle", 32'(mem_if.mem_read), 0);
    @(negedge clk); #1 chk("held_regrant", 32'(mem_if.mem_read), 1);
    wait_resp(0);
    inst_read = 0;
    repeat (3) @(negedge clk);

    // watchdog with TIMEOUT=4 and a 10-cycle stall
    chk("wd_clear_before", 32'(mem_timeout), 0);
    mem_lat = 10;
    push(1, 0, 32'h300, 4'hF, 0, 32'h77);
    data_addr = 32'h300; data_read = 1;
    wait_strobe();
    repeat (3) @(negedge clk);
    #1 chk("wd_busy4_low", 32'(mem_timeout), 0);
    @(negedge clk); #1 chk("wd_busy5_high", 32'(mem_timeout), 1);
    wait_resp(1);
    data_read = 0;
    @(negedge clk); #1 chk("wd_sticky", 32'(mem_timeout), 1);

    // async reset mid-BUSY, between edges
    mem_lat = 8;
    push(0, 0, 32'h400, 4'hF, 0, 32'h99);
    inst_addr = 32'h400; inst_read = 1;
    wait_strobe();
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("arst_strobes", 32'({mem_if.mem_read, mem_if.mem_write}), 0);
    chk("arst_addr", mem_if.mem_addr, 0);
    chk("arst_mbe", 32'(mem_if.mem_mbe), 0);
    chk("arst_timeout", 32'(mem_timeout), 0);
    chk("arst_inst_rdata", inst_rdata, 0);
    rq.delete();
    inst_read = 0;
    @(negedge clk); @(negedge clk); #1 rst_n = 1;
    base = resp_cnt;
    @(negedge clk); #1 stray = 1;
    @(negedge clk); #1 stray = 0;
    repeat (4) @(negedge clk);
    chk("stray_no_resp", resp_cnt, base);
    chk("stray_no_strobe", 32'(mem_if.mem_read), 0);

    // fresh fetch after reset
    mem_lat = 1;
    push(0, 0, 32'h500, 4'hF, 0, 32'hCAFEF00D);
    inst_addr = 32'h500; inst_read = 1;
    wait_resp(0);
    inst_read = 0;
    repeat (4) @(negedge clk);
    chk("mq_drained", mq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
